// File: rtl/scs8hd_a41o_bist.sv
// Self-test sequencer for an a41o cell (X = A1&A2&A3&A4 | B1).
// Sweeps all 32 input patterns, samples X after SETTLE edges per pattern,
// and reports a saturating mismatch count, the first failing pattern and
// a pass flag.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for START; pattern parked at 0, results held
// RUN   | pattern driven, settle counter running, sample on count 1
// FIN   | one-cycle DONE pulse; START here begins a new run at once
module scs8hd_a41o_bist #(
  parameter int SETTLE = 1,
  parameter int ERR_W  = 6
) (
  input  logic             CLK,
  input  logic             RESETB,
  input  logic             START,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic             A1,
  output logic             A2,
  output logic             A3,
  output logic             A4,
  output logic             B1,
  input  logic             X,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic [4:0]       FAIL_PAT,
  output logic             FAIL_VLD
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  localparam logic [3:0]       SETTLE_LD = 4'(SETTLE);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;

  state_t           state;
  logic [4:0]       pat;
  logic [3:0]       cnt;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;
  logic [4:0]       fail_pat;
  logic             fail_vld;

  logic             gold;
  logic             mismatch;
  logic [ERR_W-1:0] err_next;

  // Golden model and the error count as it would stand after this sample.
  // The case-inequality makes an unknown or floating X count as a miss.
  always_comb begin
    gold     = (pat[3:0] == 4'hF) | pat[4];
    mismatch = (X !== gold);
    err_next = err_cnt;
    if (mismatch && (err_cnt != ERR_MAX)) begin
      err_next = err_cnt + 1'b1;
    end
  end

  // Sequencer: pattern sweep, settle timing, result capture.
  always_ff @(posedge CLK) begin
    if (!RESETB) begin
      state    <= S_IDLE;
      pat      <= 5'd0;
      cnt      <= 4'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_cnt  <= '0;
      fail_pat <= 5'd0;
      fail_vld <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_FIN: begin
          done <= 1'b0;
          busy <= 1'b0;
          pat  <= 5'd0;
          if (START) begin
            state    <= S_RUN;
            busy     <= 1'b1;
            cnt      <= SETTLE_LD;
            pass     <= 1'b0;
            err_cnt  <= '0;
            fail_pat <= 5'd0;
            fail_vld <= 1'b0;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (cnt == 4'd1) begin
            err_cnt <= err_next;
            if (mismatch && !fail_vld) begin
              fail_pat <= pat;
              fail_vld <= 1'b1;
            end
            if (pat == 5'd31) begin
              state <= S_FIN;
              done  <= 1'b1;
              busy  <= 1'b0;
              pat   <= 5'd0;
              pass  <= (err_next == '0);
            end else begin
              pat <= pat + 5'd1;
              cnt <= SETTLE_LD;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          pat   <= 5'd0;
        end
      endcase
    end
  end

  assign {B1, A4, A3, A2, A1} = pat;
  assign BUSY     = busy;
  assign DONE     = done;
  assign PASS     = pass;
  assign ERR_CNT  = err_cnt;
  assign FAIL_PAT = fail_pat;
  assign FAIL_VLD = fail_vld;

endmodule

// File: tb/tb_scs8hd_a41o_bist.sv
// Bench for scs8hd_a41o_bist: three instances (SETTLE=1/ERR_W=6,
// SETTLE=2/ERR_W=6, SETTLE=1/ERR_W=4) each driving a cell model whose
// output can be flipped per pattern by a mask and optionally delayed by
// one register stage.
module tb_scs8hd_a41o_bist;

  logic        CLK = 1'b0;
  logic        RESETB = 1'b0;
  logic [2:0]  start = 3'b000;
  logic [2:0]  x_in;
  logic [2:0]  busy, done, pass, fvld;
  logic [4:0]  pat0, pat1, pat2;
  logic [4:0]  fp0, fp1, fp2;
  logic [5:0]  err0, err1;
  logic [3:0]  err2;
  logic [31:0] mask [3];
  logic [2:0]  regmode = 3'b000;
  logic [2:0]  xreg = 3'b000;
  logic [31:0] goldvec;

  int n_chk = 0;
  int n_pass = 0;

  always #5 CLK = ~CLK;

  function automatic logic gold(input int p);
    return ((p % 16) == 15) || (p >= 16);
  endfunction

  scs8hd_a41o_bist #(.SETTLE(1), .ERR_W(6)) dut0 (
    .CLK(CLK), .RESETB(RESETB), .START(start[0]), .BUSY(busy[0]), .DONE(done[0]),
    .PASS(pass[0]), .A1(pat0[0]), .A2(pat0[1]), .A3(pat0[2]), .A4(pat0[3]), .B1(pat0[4]),
    .X(x_in[0]), .ERR_CNT(err0), .FAIL_PAT(fp0), .FAIL_VLD(fvld[0]));

  scs8hd_a41o_bist #(.SETTLE(2), .ERR_W(6)) dut1 (
    .CLK(CLK), .RESETB(RESETB), .START(start[1]), .BUSY(busy[1]), .DONE(done[1]),
    .PASS(pass[1]), .A1(pat1[0]), .A2(pat1[1]), .A3(pat1[2]), .A4(pat1[3]), .B1(pat1[4]),
    .X(x_in[1]), .ERR_CNT(err1), .FAIL_PAT(fp1), .FAIL_VLD(fvld[1]));

  scs8hd_a41o_bist #(.SETTLE(1), .ERR_W(4)) dut2 (
    .CLK(CLK), .RESETB(RESETB), .START(start[2]), .BUSY(busy[2]), .DONE(done[2]),
    .PASS(pass[2]), .A1(pat2[0]), .A2(pat2[1]), .A3(pat2[2]), .A4(pat2[3]), .B1(pat2[4]),
    .X(x_in[2]), .ERR_CNT(err2), .FAIL_PAT(fp2), .FAIL_VLD(fvld[2]));

  // Cell models: ideal or one-register a41o, with per-pattern fault mask.
  always @(posedge CLK) begin
    xreg[0] <= gold(int'(pat0));
    xreg[1] <= gold(int'(pat1));
    xreg[2] <= gold(int'(pat2));
  end

  always_comb begin
    x_in    = 3'b000;
    x_in[0] = (regmode[0] ? xreg[0] : gold(int'(pat0))) ^ mask[0][pat0];
    x_in[1] = (regmode[1] ? xreg[1] : gold(int'(pat1))) ^ mask[1][pat1];
    x_in[2] = (regmode[2] ? xreg[2] : gold(int'(pat2))) ^ mask[2][pat2];
  end

  function automatic int rd_pat(input int d);
    case (d)
      0: return int'(pat0);
      1: return int'(pat1);
      default: return int'(pat2);
    endcase
  endfunction

  function automatic int rd_err(input int d);
    case (d)
      0: return int'(err0);
      1: return int'(err1);
      default: return int'(err2);
    endcase
  endfunction

  function automatic int rd_fp(input int d);
    case (d)
      0: return int'(fp0);
      1: return int'(fp1);
      default: return int'(fp2);
    endcase
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Reference: walk the 32 patterns, decide what the cell returns at the
  // sample point, and tally misses.
  task automatic model(input logic [31:0] m, input bit rm, input int settle,
                       input int errw, output int e, output int fp, output int fv);
    int cap;
    logic seen;
    e = 0; fp = 0; fv = 0;
    for (int k = 0; k < 32; k++) begin
      seen = (rm && settle == 1) ? gold(k == 0 ? 0 : k - 1) : gold(k);
      seen = seen ^ m[k];
      if (seen != gold(k)) begin
        e++;
        if (fv == 0) begin fp = k; fv = 1; end
      end
    end
    cap = (1 << errw) - 1;
    if (e > cap) e = cap;
  endtask

  task automatic check_results(input string tag, input int d, input logic [31:0] m,
                               input bit rm, input int settle, input int errw);
    int e, fp, fv;
    model(m, rm, settle, errw, e, fp, fv);
    chk({tag, "_err"}, rd_err(d), e);
    chk({tag, "_fvld"}, int'(fvld[d]), fv);
    chk({tag, "_fpat"}, rd_fp(d), fp);
    chk({tag, "_pass"}, int'(pass[d]), (e == 0) ? 1 : 0);
  endtask

  task automatic run_test(input string tag, input int d, input int settle,
                          input logic [31:0] m, input bit rm, input int errw,
                          input int repulse);
    int cyc, busy_n, bad_pat, done_at;
    bit pulsed;
    mask[d] = m;
    regmode[d] = rm;
    repeat ($urandom_range(0, 3)) @(negedge CLK);
    @(negedge CLK);
    start[d] = 1'b1;
    @(posedge CLK);
    #1 start[d] = 1'b0;
    cyc = 0; busy_n = 0; bad_pat = 0; done_at = -1; pulsed = 0;
    while (done_at < 0 && cyc < 40 * settle + 10) begin
      @(negedge CLK);
      if (busy[d]) begin
        busy_n++;
        if (rd_pat(d) != cyc / settle) bad_pat++;
      end
      if (done[d]) done_at = cyc;
      if (start[d]) start[d] = 1'b0;
      else if (repulse >= 0 && !pulsed && busy[d] && rd_pat(d) == repulse) begin
        start[d] = 1'b1;
        pulsed = 1;
      end
      cyc++;
    end
    start[d] = 1'b0;
    if (done_at < 0) chk({tag, "_timeout"}, cyc, -1);
    chk({tag, "_busy_cycles"}, busy_n, 32 * settle);
    chk({tag, "_done_cycle"}, done_at, 32 * settle);
    chk({tag, "_sweep"}, bad_pat, 0);
    check_results(tag, d, m, rm, settle, errw);
    @(negedge CLK);
    chk({tag, "_done_pulse"}, int'(done[d]), 0);
    chk({tag, "_pass_hold"}, int'(pass[d]), (rd_err(d) == 0) ? 1 : 0);
  endtask

  task automatic wait_done(input string tag, input int d, input int budget);
    int n;
    n = 0;
    while (!done[d] && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (!done[d]) chk({tag, "_timeout"}, n, -1);
  endtask

  initial begin
    logic [31:0] m1, m2;
    int n_done, n_busy, n;

    for (int d = 0; d < 3; d++) mask[d] = 32'h0;
    for (int k = 0; k < 32; k++) goldvec[k] = gold(k);

    repeat (3) @(negedge CLK);
    RESETB = 1'b1;
    @(negedge CLK);
    chk("rst_busy", int'(busy[0]), 0);
    chk("rst_done", int'(done[0]), 0);
    chk("rst_pass", int'(pass[0]), 0);
    chk("rst_err", rd_err(0), 0);
    chk("rst_fpat", rd_fp(0), 0);
    chk("rst_fvld", int'(fvld[0]), 0);
    chk("rst_pat", rd_pat(0), 0);

    run_test("good_s1", 0, 1, 32'h0, 1'b0, 6, -1);
    chk("good_s1_pass_const", int'(pass[0]), 1);

    run_test("stuck0", 0, 1, goldvec, 1'b0, 6, -1);
    chk("stuck0_err_const", rd_err(0), 17);
    chk("stuck0_fpat_const", rd_fp(0), 15);

    run_test("stuck1", 0, 1, ~goldvec, 1'b0, 6, -1);
    chk("stuck1_err_const", rd_err(0), 15);
    chk("stuck1_fpat_const", rd_fp(0), 0);

    run_test("sat_w4", 2, 1, goldvec, 1'b0, 4, -1);
    chk("sat_w4_err_const", rd_err(2), 15);

    run_test("reg_s2", 1, 2, 32'h0, 1'b1, 6, -1);
    run_test("reg_s1", 0, 1, 32'h0, 1'b1, 6, -1);
    chk("reg_s1_pass_const", int'(pass[0]), 0);

    for (int i = 0; i < 6; i++) begin
      m1 = (i == 5) ? $urandom : ($urandom & $urandom & $urandom);
      run_test($sformatf("rand%0d", i), 0, 1, m1, 1'b0, 6, -1);
    end
    m1 = $urandom & $urandom;
    run_test("rand_w4", 2, 1, m1, 1'b0, 4, -1);
    m1 = $urandom & $urandom;
    run_test("rand_s2", 1, 2, m1, 1'b0, 6, -1);

    m1 = $urandom & $urandom;
    run_test("repulse10", 0, 1, m1, 1'b0, 6, 10);

    // START held through FIN: a second run begins at once with clean results.
    m1 = $urandom | 32'h1;
    m2 = $urandom & $urandom;
    mask[0] = m1;
    regmode[0] = 1'b0;
    @(negedge CLK);
    start[0] = 1'b1;
    @(posedge CLK);
    #1;
    wait_done("b2b_first", 0, 60);
    check_results("b2b_first", 0, m1, 1'b0, 1, 6);
    @(negedge CLK);
    chk("b2b_busy", int'(busy[0]), 1);
    chk("b2b_err_clr", rd_err(0), 0);
    chk("b2b_fvld_clr", int'(fvld[0]), 0);
    chk("b2b_pass_clr", int'(pass[0]), 0);
    chk("b2b_pat", rd_pat(0), 0);
    mask[0] = m2;
    start[0] = 1'b0;
    wait_done("b2b_second", 0, 60);
    check_results("b2b_second", 0, m2, 1'b0, 1, 6);

    // Reset mid-run at pattern 20: outputs clear, no DONE follows.
    repeat (2) @(negedge CLK);
    mask[0] = $urandom | 32'h1;
    start[0] = 1'b1;
    @(negedge CLK);
    start[0] = 1'b0;
    n = 0;
    while (rd_pat(0) != 20 && n < 60) begin
      @(negedge CLK);
      n++;
    end
    if (rd_pat(0) != 20) chk("rst_mid_timeout", n, -1);
    RESETB = 1'b0;
    @(negedge CLK);
    chk("rst_mid_pat", rd_pat(0), 0);
    chk("rst_mid_busy", int'(busy[0]), 0);
    chk("rst_mid_err", rd_err(0), 0);
    chk("rst_mid_fvld", int'(fvld[0]), 0);
    chk("rst_mid_fpat", rd_fp(0), 0);
    chk("rst_mid_pass", int'(pass[0]), 0);
    RESETB = 1'b1;
    n_done = 0;
    n_busy = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge CLK);
      if (done[0]) n_done++;
      if (busy[0]) n_busy++;
    end
    chk("rst_mid_no_done", n_done, 0);
    chk("rst_mid_no_busy", n_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
